// File: rtl/dport_wbuf.sv
// Posted-write buffer in front of the AXI data-port bridge: writes are queued and acked
// immediately, while reads and cache-maintenance ops wait until every write has drained.
module dport_wbuf #(
    parameter int DEPTH           = 4,
    parameter int DEPTH_W         = 2,
    parameter int MAX_OUTSTANDING = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic        mem_cacheable_i,
    input  logic [10:0] mem_req_tag_i,
    input  logic        mem_invalidate_i,
    input  logic        mem_writeback_i,
    input  logic        mem_flush_i,
    output logic [31:0] mem_data_rd_o,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic        mem_error_o,
    output logic [10:0] mem_resp_tag_o,
    output logic [31:0] ext_addr_o,
    output logic [31:0] ext_data_wr_o,
    output logic        ext_rd_o,
    output logic [3:0]  ext_wr_o,
    output logic        ext_cacheable_o,
    output logic [10:0] ext_req_tag_o,
    output logic        ext_invalidate_o,
    output logic        ext_writeback_o,
    output logic        ext_flush_o,
    input  logic [31:0] ext_data_rd_i,
    input  logic        ext_accept_i,
    input  logic        ext_ack_i,
    input  logic        ext_error_i,
    input  logic [10:0] ext_resp_tag_i,
    output logic        wr_error_o,
    output logic        idle_o
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fifoAddr_q  [DEPTH];
    logic [31:0]        fifoData_q  [DEPTH];
    logic [3:0]         fifoStrb_q  [DEPTH];
    logic [10:0]        fifoTag_q   [DEPTH];
    logic               fifoCache_q [DEPTH];
    logic [DEPTH_W-1:0] wrPtr_q, rdPtr_q;
    logic [DEPTH_W:0]   count_q;
    logic [3:0]         outstanding_q;
    logic               wrError_q;

    logic [31:0] rdAddr_q, rdData_q;
    logic [10:0] rdTag_q;
    logic        rdRd_q, rdCache_q, rdInv_q, rdWb_q, rdFlush_q;

    logic        ack_q, err_q;
    logic [31:0] respData_q;
    logic [10:0] respTag_q;

    logic isWrite, isRead, fifoEmpty, fifoFull, presentWr, pop, acceptWr, acceptRd, wrAck;

    always_comb begin
        isWrite   = |mem_wr_i;
        isRead    = mem_rd_i | mem_invalidate_i | mem_writeback_i | mem_flush_i;
        fifoEmpty = (count_q == '0);
        fifoFull  = (count_q == (DEPTH_W+1)'(DEPTH));
        presentWr = rst_i && (state_q == IDLE) && !fifoEmpty
                    && (outstanding_q < 4'(MAX_OUTSTANDING));
        pop       = presentWr && ext_accept_i;
        acceptWr  = rst_i && isWrite && (state_q == IDLE) && !fifoFull;
        acceptRd  = rst_i && isRead && !isWrite && (state_q == IDLE) && fifoEmpty
                    && (outstanding_q == '0) && !presentWr;
        wrAck     = ext_ack_i && (state_q != RD_WAIT);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (acceptRd)     state_d = RD_ISSUE;
            RD_ISSUE: if (ext_accept_i) state_d = RD_WAIT;
            RD_WAIT:  if (ext_ack_i)    state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Downstream mux: the latched read/CMO while issuing, otherwise the FIFO head if allowed.
    always_comb begin
        ext_addr_o       = '0;
        ext_data_wr_o    = '0;
        ext_rd_o         = 1'b0;
        ext_wr_o         = '0;
        ext_cacheable_o  = 1'b0;
        ext_req_tag_o    = '0;
        ext_invalidate_o = 1'b0;
        ext_writeback_o  = 1'b0;
        ext_flush_o      = 1'b0;
        if (state_q == RD_ISSUE) begin
            ext_addr_o       = rdAddr_q;
            ext_data_wr_o    = rdData_q;
            ext_rd_o         = rdRd_q;
            ext_cacheable_o  = rdCache_q;
            ext_req_tag_o    = rdTag_q;
            ext_invalidate_o = rdInv_q;
            ext_writeback_o  = rdWb_q;
            ext_flush_o      = rdFlush_q;
        end else if (presentWr) begin
            ext_addr_o      = fifoAddr_q[rdPtr_q];
            ext_data_wr_o   = fifoData_q[rdPtr_q];
            ext_wr_o        = fifoStrb_q[rdPtr_q];
            ext_cacheable_o = fifoCache_q[rdPtr_q];
            ext_req_tag_o   = fifoTag_q[rdPtr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (acceptWr) begin
            fifoAddr_q[wrPtr_q]  <= mem_addr_i;
            fifoData_q[wrPtr_q]  <= mem_data_wr_i;
            fifoStrb_q[wrPtr_q]  <= mem_wr_i;
            fifoTag_q[wrPtr_q]   <= mem_req_tag_i;
            fifoCache_q[wrPtr_q] <= mem_cacheable_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            wrError_q     <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            respData_q    <= '0;
            respTag_q     <= '0;
            rdAddr_q      <= '0;
            rdData_q      <= '0;
            rdTag_q       <= '0;
            rdRd_q        <= 1'b0;
            rdCache_q     <= 1'b0;
            rdInv_q       <= 1'b0;
            rdWb_q        <= 1'b0;
            rdFlush_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acceptWr) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)      rdPtr_q <= rdPtr_q + 1'b1;
            if (acceptWr && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !acceptWr) count_q <= count_q - 1'b1;
            if (pop && !(wrAck && outstanding_q != '0))      outstanding_q <= outstanding_q + 1'b1;
            else if (!pop && wrAck && outstanding_q != '0)   outstanding_q <= outstanding_q - 1'b1;
            if (wrAck && ext_error_i) wrError_q <= 1'b1;
            if (acceptRd) begin
                rdAddr_q  <= mem_addr_i;
                rdData_q  <= mem_data_wr_i;
                rdTag_q   <= mem_req_tag_i;
                rdRd_q    <= mem_rd_i;
                rdCache_q <= mem_cacheable_i;
                rdInv_q   <= mem_invalidate_i;
                rdWb_q    <= mem_writeback_i;
                rdFlush_q <= mem_flush_i;
            end
            // Posted writes are acked right away; the read ack is the registered ext response.
            if (acceptWr) begin
                ack_q      <= 1'b1;
                err_q      <= 1'b0;
                respData_q <= '0;
                respTag_q  <= mem_req_tag_i;
            end else if (state_q == RD_WAIT && ext_ack_i) begin
                ack_q      <= 1'b1;
                err_q      <= ext_error_i;
                respData_q <= ext_data_rd_i;
                respTag_q  <= ext_resp_tag_i;
            end else begin
                ack_q      <= 1'b0;
                err_q      <= 1'b0;
                respData_q <= '0;
                respTag_q  <= '0;
            end
        end
    end

    assign mem_accept_o   = acceptWr | acceptRd;
    assign mem_ack_o      = ack_q;
    assign mem_error_o    = err_q;
    assign mem_data_rd_o  = respData_q;
    assign mem_resp_tag_o = respTag_q;
    assign wr_error_o     = wrError_q;
    assign idle_o         = fifoEmpty && (outstanding_q == '0) && (state_q == IDLE);

endmodule
